// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: receive side of a multiplexed 4-digit, active-low an/seg display bus.
// It samples the scan bus and rebuilds the nibble, decimal point and glyph kind of each
// digit. When all four digits have been captured it publishes them as one atomic frame.
//
// Optional feature: define SEG_SCAN_ERR_CNT_EN to build the saturating error counter.
// Without it, err_cnt is tied to zero and no counter logic is built.
//
// Lock state machine:
//   state        | meaning
//   ST_UNLOCKED  | no frame completed since reset or since the last timeout
//   ST_LOCKED    | a frame has completed and digits have kept arriving in time

module seg_scan_decoder #(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  an,
    input  logic [7:0]  seg,
    output logic [15:0] digits,
    output logic [3:0]  dp,
    output logic [7:0]  kind,
    output logic        frame_valid,
    output logic        locked,
    output logic [7:0]  err_cnt
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    localparam logic [SW-1:0] STABLE_SAT = SW'(STABLE_CYCLES);
    localparam logic [SW-1:0] STABLE_ACC = SW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TO_SAT     = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TO_PRE     = TW'(TIMEOUT_CYCLES - 2);

    localparam logic [1:0] KIND_HEX   = 2'b00;
    localparam logic [1:0] KIND_BLANK = 2'b01;
    localparam logic [1:0] KIND_MINUS = 2'b10;
    localparam logic [1:0] KIND_BAD   = 2'b11;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_t;

    // Maps an active-low gfedcba pattern to {kind, nibble}.
    function automatic logic [5:0] seg_decode(input logic [6:0] s);
        logic [5:0] r;
        case (s)
            7'h40:   r = {KIND_HEX, 4'h0};
            7'h79:   r = {KIND_HEX, 4'h1};
            7'h24:   r = {KIND_HEX, 4'h2};
            7'h30:   r = {KIND_HEX, 4'h3};
            7'h19:   r = {KIND_HEX, 4'h4};
            7'h12:   r = {KIND_HEX, 4'h5};
            7'h02:   r = {KIND_HEX, 4'h6};
            7'h78:   r = {KIND_HEX, 4'h7};
            7'h00:   r = {KIND_HEX, 4'h8};
            7'h10:   r = {KIND_HEX, 4'h9};
            7'h08:   r = {KIND_HEX, 4'hA};
            7'h03:   r = {KIND_HEX, 4'hB};
            7'h46:   r = {KIND_HEX, 4'hC};
            7'h21:   r = {KIND_HEX, 4'hD};
            7'h06:   r = {KIND_HEX, 4'hE};
            7'h0E:   r = {KIND_HEX, 4'hF};
            7'h7F:   r = {KIND_BLANK, 4'h0};
            7'h3F:   r = {KIND_MINUS, 4'h0};
            default: r = {KIND_BAD, 4'h0};
        endcase
        return r;
    endfunction

    // Input sample stage and the previous sample, used for stability detection.
    logic [3:0]    an_s_q,  an_s_d;
    logic [7:0]    seg_s_q, seg_s_d;
    logic [3:0]    an_p_q,  an_p_d;
    logic [7:0]    seg_p_q, seg_p_d;

    logic [SW-1:0] stab_cnt_q, stab_cnt_d;
    logic [TW-1:0] to_cnt_q,   to_cnt_d;
    logic [3:0]    seen_q,     seen_d;

    logic [15:0]   sh_digits_q, sh_digits_d;
    logic [3:0]    sh_dp_q,     sh_dp_d;
    logic [7:0]    sh_kind_q,   sh_kind_d;

    logic [15:0]   digits_q,  digits_d;
    logic [3:0]    dp_q,      dp_d;
    logic [7:0]    kind_q,    kind_d;
    logic          frame_valid_q, frame_valid_d;

    lock_state_t   state_q, state_d;

    logic          bus_same;
    logic          hold_done;
    logic          an_onehot;
    logic [3:0]    digit_sel;
    logic          accept;
    logic [5:0]    dec;
    logic [3:0]    seen_next;

    // The held value lives in the *_p stage once the counter has seen it repeat.
    always_comb begin
        an_s_d    = an;
        seg_s_d   = seg;
        an_p_d    = an_s_q;
        seg_p_d   = seg_s_q;
        bus_same  = ({an_s_q, seg_s_q} == {an_p_q, seg_p_q});
        hold_done = (stab_cnt_q == STABLE_ACC);
        if (!bus_same) begin
            stab_cnt_d = '0;
        end else if (stab_cnt_q != STABLE_SAT) begin
            stab_cnt_d = stab_cnt_q + 1'b1;
        end else begin
            stab_cnt_d = stab_cnt_q;
        end
    end

    // Digit select from the held anode pattern; only single-low patterns qualify.
    always_comb begin
        digit_sel = 4'b0000;
        an_onehot = 1'b0;
        case (an_p_q)
            4'b1110: begin digit_sel = 4'b0001; an_onehot = 1'b1; end
            4'b1101: begin digit_sel = 4'b0010; an_onehot = 1'b1; end
            4'b1011: begin digit_sel = 4'b0100; an_onehot = 1'b1; end
            4'b0111: begin digit_sel = 4'b1000; an_onehot = 1'b1; end
            default: begin digit_sel = 4'b0000; an_onehot = 1'b0; end
        endcase
        accept = hold_done && an_onehot;
        dec    = seg_decode(seg_p_q[6:0]);
    end

    // Shadow capture, frame publication, timeout and lock state.
    always_comb begin
        sh_digits_d   = sh_digits_q;
        sh_dp_d       = sh_dp_q;
        sh_kind_d     = sh_kind_q;
        digits_d      = digits_q;
        dp_d          = dp_q;
        kind_d        = kind_q;
        seen_d        = seen_q;
        state_d       = state_q;
        frame_valid_d = 1'b0;
        seen_next     = seen_q | digit_sel;

        if (accept) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != TO_SAT) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end else begin
            to_cnt_d = to_cnt_q;
        end

        if (accept) begin
            for (int i = 0; i < 4; i++) begin
                if (digit_sel[i]) begin
                    sh_digits_d[4*i +: 4] = dec[3:0];
                    sh_kind_d[2*i +: 2]   = dec[5:4];
                    sh_dp_d[i]            = ~seg_p_q[7];
                end
            end
            if (seen_next == 4'hF) begin
                // Publish straight from the updated shadow so the frame lands one cycle after the accept.
                digits_d      = sh_digits_d;
                dp_d          = sh_dp_d;
                kind_d        = sh_kind_d;
                frame_valid_d = 1'b1;
                state_d       = ST_LOCKED;
                seen_d        = 4'b0000;
            end else begin
                seen_d = seen_next;
            end
        end else if (to_cnt_q == TO_PRE) begin
            // Counter is about to reach its terminal value: drop lock, keep last frame.
            seen_d  = 4'b0000;
            state_d = ST_UNLOCKED;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_s_q        <= 4'hF;
            seg_s_q       <= 8'hFF;
            an_p_q        <= 4'hF;
            seg_p_q       <= 8'hFF;
            stab_cnt_q    <= '0;
            to_cnt_q      <= '0;
            seen_q        <= 4'b0000;
            sh_digits_q   <= 16'h0000;
            sh_dp_q       <= 4'b0000;
            sh_kind_q     <= 8'h00;
            digits_q      <= 16'h0000;
            dp_q          <= 4'b0000;
            kind_q        <= 8'h00;
            frame_valid_q <= 1'b0;
            state_q       <= ST_UNLOCKED;
        end else begin
            an_s_q        <= an_s_d;
            seg_s_q       <= seg_s_d;
            an_p_q        <= an_p_d;
            seg_p_q       <= seg_p_d;
            stab_cnt_q    <= stab_cnt_d;
            to_cnt_q      <= to_cnt_d;
            seen_q        <= seen_d;
            sh_digits_q   <= sh_digits_d;
            sh_dp_q       <= sh_dp_d;
            sh_kind_q     <= sh_kind_d;
            digits_q      <= digits_d;
            dp_q          <= dp_d;
            kind_q        <= kind_d;
            frame_valid_q <= frame_valid_d;
            state_q       <= state_d;
        end
    end

`ifdef SEG_SCAN_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       multi_hold;
    logic       bad_accept;

    // Count stable ghost (multi-anode) holds and accepted undecodable glyphs, saturating.
    always_comb begin
        multi_hold = hold_done && (an_p_q != 4'hF) && !an_onehot;
        bad_accept = accept && (dec[5:4] == KIND_BAD);
        err_cnt_d  = err_cnt_q;
        if ((multi_hold || bad_accept) && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Error counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= 8'h00;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'h00;
`endif

    assign digits      = digits_q;
    assign dp          = dp_q;
    assign kind        = kind_q;
    assign frame_valid = frame_valid_q;
    assign locked      = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder (STABLE_CYCLES=4, TIMEOUT_CYCLES=64).
// Expected frames are queued when a scan is driven and compared when frame_valid pulses.

module tb_seg_scan_decoder;

    localparam int STABLE  = 4;
    localparam int TIMEOUT = 64;

`ifdef SEG_SCAN_ERR_CNT_EN
    localparam int ERR_AFTER_GHOST = 1;
    localparam int ERR_AFTER_BAD   = 2;
`else
    localparam int ERR_AFTER_GHOST = 0;
    localparam int ERR_AFTER_BAD   = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [7:0]  kind;
    logic        frame_valid;
    logic        locked;
    logic [7:0]  err_cnt;

    typedef struct {
        logic [15:0] d;
        logic [3:0]  p;
        logic [7:0]  k;
    } frame_t;

    frame_t sb[$];
    int     checks = 0;
    int     errors = 0;
    int     frames = 0;

    seg_scan_decoder #(
        .STABLE_CYCLES (STABLE),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .an         (an),
        .seg        (seg),
        .digits     (digits),
        .dp         (dp),
        .kind       (kind),
        .frame_valid(frame_valid),
        .locked     (locked),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every frame_valid pulse must match the oldest queued frame.
    always @(negedge clk) begin
        if (frame_valid === 1'b1) begin
            frame_t f;
            frames++;
            check("frame_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                f = sb.pop_front();
                check("frame_digits", 32'(digits), 32'(f.d));
                check("frame_dp",     32'(dp),     32'(f.p));
                check("frame_kind",   32'(kind),   32'(f.k));
            end
        end
    end

    task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n);
        an  = a;
        seg = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [15:0] d, input logic [3:0] p, input logic [7:0] k);
        frame_t f;
        f.d = d;
        f.p = p;
        f.k = k;
        sb.push_back(f);
    endtask

    task automatic scan(input logic [7:0] s3, input logic [7:0] s2,
                        input logic [7:0] s1, input logic [7:0] s0);
        hold(4'h7, s3, 8);
        hold(4'hB, s2, 8);
        hold(4'hD, s1, 8);
        hold(4'hE, s0, 8);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int f0;
        rst = 1'b1;
        an  = 4'hF;
        seg = 8'hFF;
        repeat (3) @(negedge clk);
        check("rst_digits", 32'(digits), 32'h0);
        check("rst_dp",     32'(dp),     32'h0);
        check("rst_kind",   32'(kind),   32'h0);
        check("rst_fv",     32'(frame_valid), 32'h0);
        check("rst_locked", 32'(locked), 32'h0);
        check("rst_err",    32'(err_cnt), 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // "0123": digit 3 = 0 ... digit 0 = 3
        push(16'h0123, 4'h0, 8'h00);
        scan(8'hC0, 8'hF9, 8'hA4, 8'hB0);
        drain("drain_0123");
        check("locked_0123", 32'(locked), 32'd1);
        check("frames_0123", 32'(frames), 32'd1);

        // minus on digit 2, dp lit on digit 0
        push(16'h0023, 4'b0001, 8'h20);
        scan(8'hC0, 8'hBF, 8'hA4, 8'h30);
        drain("drain_minus");

        // glitch between digits 1 and 0 after three accepts; seen must survive
        f0 = frames;
        push(16'h4567, 4'h0, 8'h00);
        hold(4'h7, 8'h99, 8);
        hold(4'hB, 8'h92, 8);
        hold(4'hD, 8'h82, 8);
        for (int i = 0; i < 20; i++) begin
            hold(((i % 2) == 0) ? 4'hE : 4'hD, 8'hF8, 2);
        end
        check("glitch_no_frame", 32'(frames), 32'(f0));
        hold(4'hE, 8'hF8, 8);
        drain("drain_glitch");

        // ghost anodes held before the last digit: never accepted
        f0 = frames;
        push(16'h89BD, 4'h0, 8'h00);
        hold(4'h7, 8'h80, 8);
        hold(4'hB, 8'h90, 8);
        hold(4'hD, 8'h83, 8);
        hold(4'h3, 8'h86, 8);
        check("ghost_no_frame", 32'(frames), 32'(f0));
        hold(4'hE, 8'hA1, 8);
        drain("drain_ghost");
        check("ghost_err", 32'(err_cnt), 32'(ERR_AFTER_GHOST));

        // blank, A, F, bad glyph
        push(16'h0AF0, 4'h0, 8'h43);
        scan(8'hFF, 8'h88, 8'h8E, 8'hD5);
        drain("drain_mixed");
        check("bad_err", 32'(err_cnt), 32'(ERR_AFTER_BAD));
        check("locked_mixed", 32'(locked), 32'd1);

        // timeout: blanking gap only
        hold(4'hF, 8'hFF, 40);
        check("to_still_locked", 32'(locked), 32'd1);
        hold(4'hF, 8'hFF, 30);
        check("to_unlocked", 32'(locked), 32'd0);
        check("to_digits", 32'(digits), 32'h0AF0);
        check("to_kind",   32'(kind),   32'h43);

        // reset after three accepted digits discards the partial frame
        hold(4'h7, 8'hC6, 8);
        hold(4'hB, 8'h86, 8);
        hold(4'hD, 8'hA1, 8);
        an  = 4'hF;
        seg = 8'hFF;
        rst = 1'b1;
        #2;
        check("mid_rst_digits", 32'(digits), 32'h0);
        check("mid_rst_kind",   32'(kind),   32'h0);
        check("mid_rst_dp",     32'(dp),     32'h0);
        check("mid_rst_locked", 32'(locked), 32'h0);
        check("mid_rst_err",    32'(err_cnt), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        f0 = frames;
        hold(4'hE, 8'h83, 8);
        hold(4'hF, 8'hFF, 4);
        check("rst_partial_no_frame", 32'(frames), 32'(f0));
        push(16'hCEDB, 4'h0, 8'h00);
        scan(8'hC6, 8'h86, 8'hA1, 8'h83);
        drain("drain_after_rst");
        check("frames_total", 32'(frames), 32'(f0 + 1));
        check("locked_final", 32'(locked), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
